shift_arbiter: RTL and testbench

Shares a single combinational 32-bit shift core between two requesters (e.g. ALU issue and address-generation) with round-robin arbitration and a valid/ready handshake on both request and response sides. Sits between the requesters and the shifter datapath; it latches operands, sequences one shift at a time, and holds the registered result until the consumer accepts it.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_core.sv | 31 +++
 rtl/shift_arbiter.sv | 107 ++++++++++
 tb/tb_shift_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the two-requester shift arbiter.
// Op and FSM encodings plus the latched request bundle.
package shift_pkg;

  localparam int N          = 32;
  localparam int SHAMT_BITS = 5;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    PASS = 2'b10,
    SRA  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  typedef struct packed {
    shift_op_t    op;
    logic [N-1:0] in;
    logic [N-1:0] shamt;
    logic         id;
  } shift_req_t;

  function automatic logic [N-1:0] sat_inc(
    input logic [N-1:0] v
  );
    return (&v) ? v : v + {{(N-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: SLL/SRL/SRA with
// saturating behaviour for shift amounts of N or more.
module shift_core
  import shift_pkg::*;
(
  input  logic [N-1:0] in,
  input  logic [N-1:0] shamt,
  input  shift_op_t    op,
  output logic [N-1:0] out
);

  logic                  big;
  logic [SHAMT_BITS-1:0] sh;
  logic [N-1:0]          sra;

  assign big = |shamt[N-1:SHAMT_BITS];
  assign sh  = shamt[SHAMT_BITS-1:0];
  // kept separate so the arithmetic shift stays signed
  assign sra = $signed(in) >>> sh;

  always_comb begin
    out = in;
    unique case (op)
      SLL:  out = big ? '0 : (in << sh);
      SRL:  out = big ? '0 : (in >> sh);
      SRA:  out = big ? {N{in[N-1]}} : sra;
      PASS: out = in;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters.
// Optional grant counters under `SHIFT_ARB_STATS_EN.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  shift_op_t    req0_op,
  input  logic [N-1:0] req0_in,
  input  logic [N-1:0] req0_shamt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  shift_op_t    req1_op,
  input  logic [N-1:0] req1_in,
  input  logic [N-1:0] req1_shamt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [N-1:0] grant_cnt0,
  output logic [N-1:0] grant_cnt1
`endif
);

  arb_state_t   state;
  logic         last_grant;
  shift_req_t   req_q;
  logic         gnt0;
  logic         gnt1;
  logic [N-1:0] core_out;

  // On a tie, the requester not granted last time wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant))
        gnt0 = 1'b1;
      else if (req1_valid)
        gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  shift_core u_core (
    .in    (req_q.in),
    .shamt (req_q.shamt),
    .op    (req_q.op),
    .out   (core_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      req_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            req_q.op    <= gnt1 ? req1_op    : req0_op;
            req_q.in    <= gnt1 ? req1_in    : req0_in;
            req_q.shamt <= gnt1 ? req1_shamt : req0_shamt;
            req_q.id    <= gnt1;
            last_grant  <= gnt1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= core_out;
          rsp_id    <= req_q.id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt0) grant_cnt0 <= sat_inc(grant_cnt0);
      if (gnt1) grant_cnt1 <= sat_inc(grant_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table,
// tie/latency/backpressure/reset sequences, response scoreboard.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  shift_op_t    req0_op;
  logic [31:0]  req0_in, req0_shamt;
  logic         req1_valid, req1_ready;
  shift_op_t    req1_op;
  logic [31:0]  req1_in, req1_shamt;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [31:0]  rsp_data;
`ifdef SHIFT_ARB_STATS_EN
  logic [31:0]  grant_cnt0, grant_cnt1;
`endif

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_in    (req0_in),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_in    (req1_in),
    .req1_shamt (req1_shamt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [32:0] q[$];
  logic [32:0] mon_e;

  typedef struct {
    bit          id;
    shift_op_t   op;
    logic [31:0] a;
    logic [31:0] sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: a handshake is visible just after inputs settle.
  always @(negedge clk) begin
    #3;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp act id=%0d data=%h",
                 rsp_id, rsp_data);
      end else begin
        mon_e = q.pop_front();
        check("rsp_id", {31'b0, rsp_id}, {31'b0, mon_e[32]});
        check("rsp_data", rsp_data, mon_e[31:0]);
      end
    end
  end

  task automatic wait_ready(input int who,
                            output bit got,
                            output bit gid);
    got = 1'b0;
    gid = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      #1;
      if (req0_ready && who != 1) begin
        got = 1'b1;
        gid = 1'b0;
      end else if (req1_ready && who != 0) begin
        got = 1'b1;
        gid = 1'b1;
      end
      if (!got) tick();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout act=none exp=who%0d", who);
    end
  endtask

  task automatic drive(input bit id, input shift_op_t op,
                       input logic [31:0] a,
                       input logic [31:0] sh);
    if (id == 1'b0) begin
      req0_valid = 1'b1;
      req0_op    = op;
      req0_in    = a;
      req0_shamt = sh;
    end else begin
      req1_valid = 1'b1;
      req1_op    = op;
      req1_in    = a;
      req1_shamt = sh;
    end
  endtask

  task automatic issue(input bit id, input shift_op_t op,
                       input logic [31:0] a,
                       input logic [31:0] sh,
                       input logic [31:0] exp);
    bit got, gid;
    drive(id, op, a, sh);
    wait_ready(id ? 1 : 0, got, gid);
    if (got) q.push_back({id, exp});
    tick();
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && q.size() != 0; c++) tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic tie_run(input int n, input bit first);
    bit got, gid;
    drive(1'b0, SRL, 32'h8000_0000, 32'd31);
    drive(1'b1, SRA, 32'h8000_0000, 32'd4);
    for (int k = 0; k < n; k++) begin
      wait_ready(2, got, gid);
      if (!got) break;
      check("tie_grant", {31'b0, gid},
            {31'b0, first ^ k[0]});
      q.push_back({gid, gid ? 32'hF800_0000 : 32'h1});
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    bit got, gid;
    vecs[0]  = '{1'b0, SLL,  32'h0000_0001, 32'd4,  32'h0000_0010};
    vecs[1]  = '{1'b1, SRL,  32'hF000_0000, 32'd8,  32'h00F0_0000};
    vecs[2]  = '{1'b0, SRA,  32'h8000_0000, 32'h20, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b1, SRL,  32'h8000_0000, 32'h20, 32'h0000_0000};
    vecs[4]  = '{1'b0, SLL,  32'hFFFF_FFFF, 32'd31, 32'h8000_0000};
    vecs[5]  = '{1'b1, SLL,  32'h0000_1234, 32'h100, 32'h0000_0000};
    vecs[6]  = '{1'b0, PASS, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, SRA,  32'h7000_0000, 32'd4,  32'h0700_0000};
    vecs[8]  = '{1'b0, SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b1, SRL,  32'h8000_0001, 32'd0,  32'h8000_0001};
    vecs[10] = '{1'b0, SRA,  32'h8000_0000, 32'h8000_0000,
                 32'hFFFF_FFFF};

    rst = 1'b0;
    req0_valid = 1'b0; req0_op = SLL;
    req0_in = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = SLL;
    req1_in = '0; req1_shamt = '0;
    rsp_ready = 1'b0;
    #2 rst = 1'b1;
    tick();
    req0_valid = 1'b1;
    tick();
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    #1;
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
`ifdef SHIFT_ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, 32'd0);
    check("rst_cnt1", grant_cnt1, 32'd0);
`endif
    tick();
    req0_valid = 1'b0;
    rst = 1'b0;
    rsp_ready = 1'b1;

    // tie straight out of reset: req0 first, then req1
    tie_run(2, 1'b0);
    drain();

    // single request latency
    drive(1'b0, SLL, 32'h1, 32'd4);
    wait_ready(0, got, gid);
    if (got) q.push_back({1'b0, 32'h10});
    tick();
    req0_valid = 1'b0;
    check("lat_e0_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("lat_e1_valid", {31'b0, rsp_valid}, 32'd1);
    drain();

    for (int i = 0; i < 11; i++)
      issue(vecs[i].id, vecs[i].op, vecs[i].a,
            vecs[i].sh, vecs[i].exp);
    drain();

    // backpressure with the other requester waiting
    rsp_ready = 1'b0;
    issue(1'b1, SLL, 32'h3, 32'd2, 32'hC);
    drive(1'b0, SLL, 32'h1, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'hC);
      check("bp_id", {31'b0, rsp_id}, 32'd1);
      #1;
      check("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    q.push_back({1'b0, 32'h2});
    tick();
    check("bp_release", {31'b0, rsp_valid}, 32'd0);
    wait_ready(0, got, gid);
    tick();
    req0_valid = 1'b0;
    drain();

    // reset while in EXEC discards the operation
    drive(1'b0, SRL, 32'h8000_0000, 32'd31);
    drive(1'b1, SRA, 32'h8000_0000, 32'd4);
    wait_ready(2, got, gid);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_id", {31'b0, rsp_id}, 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    check("mid_rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("mid_rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    check("mid_rst_hold", {31'b0, rsp_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tie_run(3, 1'b0);
    drain();
`ifdef SHIFT_ARB_STATS_EN
    check("grant_cnt0", grant_cnt0, 32'd2);
    check("grant_cnt1", grant_cnt1, 32'd1);
`endif
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
